// File: rtl/pio_wmem_rd_arb.sv
// Round-robin arbiter sharing one registered wide-memory read port among NREQ requesters; grant is combinational, issue +1, ack +5.
// Backpressure: grants withheld while app_hold is set or the tag FIFO holds OUTSTANDING reads; acks always drain.
module pio_wmem_rd_arb #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 50,
    parameter int DEPTH_NBITS = 10,
    parameter int OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_rd,
    input  logic [NREQ*DEPTH_NBITS-1:0]   req_raddr,
    output logic [NREQ-1:0]               req_gnt,
    output logic [NREQ-1:0]               req_ack,
    output logic [WIDTH-1:0]              req_rdata,
    input  logic                          app_hold,
    output logic                          app_mem_rd,
    output logic [DEPTH_NBITS-1:0]        app_mem_raddr,
    input  logic                          app_mem_ack,
    input  logic [WIDTH-1:0]              app_mem_rdata,
    output logic [$clog2(OUTSTANDING):0]  outstanding,
    output logic                          err_ack
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(OUTSTANDING);

    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         tag_mem [OUTSTANDING];
    logic [PW:0]            wr_ptr;
    logic [PW:0]            rd_ptr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   eligible;
    logic                   xfer;
    logic                   win_vld;
    logic [IDW-1:0]         win_id;
    logic [DEPTH_NBITS-1:0] win_addr;
    int                     idx;

    // Extra pointer MSB lets the difference reach OUTSTANDING without aliasing to empty.
    assign outstanding = wr_ptr - rd_ptr;
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (outstanding == (PW+1)'(OUTSTANDING));
    assign eligible    = !rst && !app_hold && !fifo_full;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!win_vld && req_rd[idx]) begin
                win_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_gnt = '0;
        if (eligible && win_vld) begin
            req_gnt[win_id] = 1'b1;
        end
    end

    assign xfer     = |(req_rd & req_gnt);
    assign win_addr = req_raddr[int'(win_id)*DEPTH_NBITS +: DEPTH_NBITS];

    always_ff @(posedge clk) begin
        if (xfer) begin
            tag_mem[wr_ptr[PW-1:0]] <= win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= IDW'(NREQ-1);
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            app_mem_rd    <= 1'b0;
            app_mem_raddr <= '0;
            req_ack       <= '0;
            req_rdata     <= '0;
            err_ack       <= 1'b0;
        end else begin
            app_mem_rd <= xfer;
            if (xfer) begin
                app_mem_raddr <= win_addr;
                wr_ptr        <= wr_ptr + 1'b1;
                ptr           <= win_id;
            end
            req_ack <= '0;
            if (app_mem_ack) begin
                // An ack with no tag to route is a memory-side protocol fault.
                if (fifo_empty) begin
                    err_ack <= 1'b1;
                end else begin
                    req_ack[tag_mem[rd_ptr[PW-1:0]]] <= 1'b1;
                    req_rdata                        <= app_mem_rdata;
                    rd_ptr                           <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_wmem_rd_arb.sv
module tb_pio_wmem_rd_arb;

    localparam int NREQ = 4;
    localparam int WIDTH = 50;
    localparam int DW = 10;
    localparam int OUTS = 4;
    localparam int OW = $clog2(OUTS) + 1;
    localparam int RW = 1 + DW + NREQ + WIDTH + OW + 1;
    localparam int OFF_OUT = 1;
    localparam int OFF_RDATA = OFF_OUT + OW;
    localparam int OFF_ACK = OFF_RDATA + WIDTH;
    localparam int OFF_RADDR = OFF_ACK + NREQ;
    localparam int OFF_MRD = OFF_RADDR + DW;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_rd;
    logic [NREQ*DW-1:0]   req_raddr;
    logic [NREQ-1:0]      req_gnt;
    logic [NREQ-1:0]      req_ack;
    logic [WIDTH-1:0]     req_rdata;
    logic                 app_hold;
    logic                 app_mem_rd;
    logic [DW-1:0]        app_mem_raddr;
    logic                 app_mem_ack;
    logic [WIDTH-1:0]     app_mem_rdata;
    logic [OW-1:0]        outstanding;
    logic                 err_ack;

    pio_wmem_rd_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DW), .OUTSTANDING(OUTS)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_raddr(req_raddr), .req_gnt(req_gnt),
        .req_ack(req_ack), .req_rdata(req_rdata), .app_hold(app_hold), .app_mem_rd(app_mem_rd),
        .app_mem_raddr(app_mem_raddr), .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
        .outstanding(outstanding), .err_ack(err_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int cyc;
    int lat;

    // Reference: in-flight requester IDs, RR position and expected registered outputs.
    int               m_ptr;
    int               m_q[$];
    logic             m_mem_rd;
    logic [DW-1:0]    m_raddr;
    logic [NREQ-1:0]  m_ack;
    logic [WIDTH-1:0] m_rdata;
    logic             m_err;

    // Behavioural memory: each read returns after lat cycles, in order.
    int               due_q[$];
    logic [DW-1:0]    addr_q[$];

    function automatic logic [WIDTH-1:0] mem_word(input logic [DW-1:0] a);
        return {a, ~a, a, ~a, a};
    endfunction

    function automatic int onehot_id(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int model_winner(input logic [NREQ-1:0] rd);
        for (int k = 1; k <= NREQ; k++) if (rd[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ptr = NREQ - 1;
        m_mem_rd = 1'b0;
        m_raddr = '0;
        m_ack = '0;
        m_rdata = '0;
        m_err = 1'b0;
        due_q.delete();
        addr_q.delete();
    endtask

    task automatic rand_addr();
        for (int i = 0; i < NREQ; i++) req_raddr[i*DW +: DW] = DW'($urandom);
    endtask

    // Drives one cycle, returns observed and expected outputs, then advances the reference.
    task automatic step(input logic [NREQ-1:0] rd, input logic hold, input logic r, input logic spur,
                        output logic [NREQ-1:0] og, output logic [NREQ-1:0] eg,
                        output logic [RW-1:0] oregs, output logic [RW-1:0] eregs);
        int w;
        req_rd = rd;
        app_hold = hold;
        rst = r;
        app_mem_ack = spur;
        app_mem_rdata = {WIDTH{1'b0}} | WIDTH'({$urandom, $urandom});
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            app_mem_ack = 1'b1;
            app_mem_rdata = mem_word(addr_q[0]);
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end
        @(negedge clk);
        oregs = {app_mem_rd, app_mem_raddr, req_ack, req_rdata, outstanding, err_ack};
        eregs = {m_mem_rd, m_raddr, m_ack, m_rdata, OW'(m_q.size()), m_err};
        og = req_gnt;
        w = (r || hold || m_q.size() >= OUTS) ? -1 : model_winner(rd);
        eg = (w < 0) ? '0 : (NREQ'(1) << w);
        if (app_mem_rd === 1'b1) begin
            due_q.push_back(cyc + lat);
            addr_q.push_back(app_mem_raddr);
        end
        if (r) begin
            model_reset();
        end else begin
            if (app_mem_ack) begin
                if (m_q.size() == 0) begin
                    m_err = 1'b1;
                    m_ack = '0;
                end else begin
                    m_ack = NREQ'(1) << m_q.pop_front();
                    m_rdata = app_mem_rdata;
                end
            end else begin
                m_ack = '0;
            end
            m_mem_rd = (w >= 0);
            if (w >= 0) begin
                m_raddr = req_raddr[w*DW +: DW];
                m_q.push_back(w);
                m_ptr = w;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        req_rd = '1;
        @(negedge clk);
        n_chk++;
        if (req_gnt !== '0) $display("FAIL reset_gnt got=%b exp=0", req_gnt);
        else n_pass++;
        n_chk++;
        if ({app_mem_rd, app_mem_raddr, req_ack, req_rdata, outstanding, err_ack} !== '0)
            $display("FAIL reset_regs got=%h exp=0", {app_mem_rd, app_mem_raddr, req_ack, req_rdata, outstanding, err_ack});
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        for (int k = 0; k < 8; k++) begin
            rand_addr();
            req_raddr[2*DW +: DW] = 10'h155;
            step((k == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL single_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL single_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k == 0) begin
                n_chk++;
                if (og !== 4'b0100) $display("FAIL single_first_gnt got=%b exp=0100", og); else n_pass++;
            end
            if (k == 1) begin
                n_chk++;
                if ({o[OFF_MRD], o[OFF_RADDR +: DW], o[OFF_OUT +: OW]} !== {1'b1, 10'h155, 3'd1})
                    $display("FAIL single_issue got=%h exp=%h", {o[OFF_MRD], o[OFF_RADDR +: DW], o[OFF_OUT +: OW]}, {1'b1, 10'h155, 3'd1});
                else n_pass++;
            end
            if (k == 5) begin
                n_chk++;
                if ({o[OFF_ACK +: NREQ], o[OFF_RDATA +: WIDTH], o[OFF_OUT +: OW]} !== {4'b0100, mem_word(10'h155), 3'd0})
                    $display("FAIL single_ack got=%h exp=%h", {o[OFF_ACK +: NREQ], o[OFF_RDATA +: WIDTH], o[OFF_OUT +: OW]}, {4'b0100, mem_word(10'h155), 3'd0});
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        int gnts[$];
        int acks[$];
        for (int k = 0; k < 30; k++) begin
            rand_addr();
            step((k > 0 && gnts.size() < 8) ? '1 : '0, 1'b0, (k == 0), 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL rr_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (og != 0) gnts.push_back(onehot_id(og));
            if (o[OFF_ACK +: NREQ] != 0) acks.push_back(onehot_id(o[OFF_ACK +: NREQ]));
        end
        n_chk++;
        if (gnts.size() != 8 || acks.size() != 8) $display("FAIL rr_count got=%0d/%0d exp=8/8", gnts.size(), acks.size());
        else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (gnts[i] != i % NREQ || acks[i] != i % NREQ)
                    $display("FAIL rr_order idx=%0d got=%0d/%0d exp=%0d", i, gnts[i], acks[i], i % NREQ);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        int last;
        int resumed;
        last = -1;
        resumed = 0;
        for (int k = 0; k < 20; k++) begin
            rand_addr();
            step((k < 12) ? '1 : '0, (k >= 3 && k <= 6), 1'b0, 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL hold_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL hold_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k >= 3 && k <= 6) begin
                n_chk++;
                if (og !== '0) $display("FAIL hold_blocked cyc=%0d got=%b exp=0", cyc, og); else n_pass++;
            end
            if (k >= 4 && k <= 7) begin
                n_chk++;
                if (o[OFF_MRD] !== 1'b0) $display("FAIL hold_no_issue cyc=%0d got=%b exp=0", cyc, o[OFF_MRD]); else n_pass++;
            end
            if (k < 3 && og != 0) last = onehot_id(og);
            if (k > 6 && og != 0 && !resumed) begin
                resumed = 1;
                n_chk++;
                if (onehot_id(og) != (last + 1) % NREQ) $display("FAIL hold_resume got=%0d exp=%0d", onehot_id(og), (last + 1) % NREQ);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        int gnts[$];
        int acks[$];
        lat = 6;
        for (int k = 0; k < 40; k++) begin
            rand_addr();
            step((k < 24) ? '1 : '0, 1'b0, 1'b0, 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL bp_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL bp_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (o[OFF_OUT +: OW] == OW'(OUTS)) begin
                n_chk++;
                if (og !== '0) $display("FAIL bp_full_gnt cyc=%0d got=%b exp=0", cyc, og); else n_pass++;
            end
            if (og != 0) gnts.push_back(onehot_id(og));
            if (o[OFF_ACK +: NREQ] != 0) acks.push_back(onehot_id(o[OFF_ACK +: NREQ]));
        end
        n_chk++;
        if (gnts.size() == 0 || acks != gnts) $display("FAIL bp_order got=%0d acks exp=%0d grants", acks.size(), gnts.size());
        else n_pass++;
        lat = 3;
    endtask

    task automatic test_spurious_ack();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        logic [DW-1:0] a1;
        a1 = '0;
        for (int k = 0; k < 12; k++) begin
            rand_addr();
            if (k == 3) a1 = req_raddr[1*DW +: DW];
            step((k == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, (k == 0), og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL spur_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL spur_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k == 1 || k == 11) begin
                n_chk++;
                if ({o[0], o[OFF_ACK +: NREQ]} !== {1'b1, 4'b0000}) $display("FAIL spur_err cyc=%0d got=%b exp=10000", cyc, {o[0], o[OFF_ACK +: NREQ]});
                else n_pass++;
            end
            if (k == 8) begin
                n_chk++;
                if ({o[OFF_ACK +: NREQ], o[OFF_RDATA +: WIDTH]} !== {4'b0010, mem_word(a1)})
                    $display("FAIL spur_read got=%h exp=%h", {o[OFF_ACK +: NREQ], o[OFF_RDATA +: WIDTH]}, {4'b0010, mem_word(a1)});
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        for (int k = 0; k < 14; k++) begin
            rand_addr();
            step((k <= 4) ? '1 : '0, 1'b0, (k == 3), 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL rstb_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL rstb_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
            if (k == 3) begin
                n_chk++;
                if (o[OFF_OUT +: OW] !== 3'd3) $display("FAIL rstb_inflight got=%0d exp=3", o[OFF_OUT +: OW]); else n_pass++;
            end
            if (k == 4) begin
                n_chk++;
                if ({o, og} !== {{RW{1'b0}}, 4'b0001}) $display("FAIL rstb_after got=%h exp=%h", {o, og}, {{RW{1'b0}}, 4'b0001});
                else n_pass++;
            end
            if (k >= 4 && k <= 8) begin
                n_chk++;
                if (o[OFF_ACK +: NREQ] !== '0) $display("FAIL rstb_stale_ack cyc=%0d got=%b exp=0", cyc, o[OFF_ACK +: NREQ]); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] og, eg;
        logic [RW-1:0] o, e;
        for (int k = 0; k < 80; k++) begin
            rand_addr();
            step((k < 70) ? NREQ'($urandom) : '0, ($urandom_range(0, 4) == 0), 1'b0, 1'b0, og, eg, o, e);
            n_chk++;
            if (og !== eg) $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); else n_pass++;
            n_chk++;
            if (o !== e) $display("FAIL rand_regs cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        lat = 3;
        rst = 1'b1;
        req_rd = '0;
        req_raddr = '0;
        app_hold = 1'b0;
        app_mem_ack = 1'b0;
        app_mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold();
        test_backpressure();
        test_spurious_ack();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
